flow_stat_arb: RTL and testbench

Access controller for the per-flow statistics RAM: one simple dual-port RAM entry per flow, accumulating packet bytes. It clears the RAM after reset and arbitrates one access per cycle between the packet-update stream and host reads. Each update is a saturating read-modify-write, with forwarding so back-to-back updates to the same flow are never lost. It sits between the packet-size FIFO and the statistics RAM instance.

---
 rtl/flow_stat_arb.sv | 196 +++++++++++++++++++
 tb/tb_flow_stat_arb.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flow_stat_arb.sv
// flow_stat_arb: clears the per-flow statistics RAM after reset, then arbitrates
// host reads and saturating packet-byte updates into a two-stage RMW pipeline.
module flow_stat_arb #(
    parameter int A_WIDTH = 10,
    parameter int D_WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               upd_val_i,
    input  logic [A_WIDTH-1:0] upd_flow_i,
    input  logic [15:0]        upd_size_i,
    output logic               upd_rdy_o,
    input  logic               rd_stb_i,
    input  logic [A_WIDTH-1:0] rd_flow_num_i,
    output logic               rd_rdy_o,
    output logic [D_WIDTH-1:0] rd_data_o,
    output logic               rd_data_val_o,
    output logic               init_done_o,
    output logic               ram_rd_en_o,
    output logic [A_WIDTH-1:0] ram_rd_addr_o,
    input  logic [D_WIDTH-1:0] ram_rd_data_i,
    output logic               ram_wr_en_o,
    output logic [A_WIDTH-1:0] ram_wr_addr_o,
    output logic [D_WIDTH-1:0] ram_wr_data_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [A_WIDTH-1:0] ADDR_ONE  = {{(A_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [A_WIDTH-1:0] ADDR_LAST = {A_WIDTH{1'b1}};

    function automatic logic [D_WIDTH-1:0] sat_add(input logic [D_WIDTH-1:0] base,
                                                   input logic [15:0]        inc);
        logic [D_WIDTH:0] sum;
        sum = {1'b0, base} + {{(D_WIDTH-15){1'b0}}, inc};
        if (sum[D_WIDTH]) begin
            sat_add = {D_WIDTH{1'b1}};
        end else begin
            sat_add = sum[D_WIDTH-1:0];
        end
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;
    logic               rr_ptr_r;      // 0: read wins the next contention
    logic [A_WIDTH-1:0] init_cnt_r;
    logic               s1_val_r;
    logic               s1_upd_r;
    logic [A_WIDTH-1:0] s1_flow_r;
    logic [15:0]        s1_size_r;
    logic               fwd_val_r;
    logic [A_WIDTH-1:0] fwd_flow_r;
    logic [D_WIDTH-1:0] fwd_data_r;
    logic [D_WIDTH-1:0] rd_data_r;
    logic               rd_data_val_r;
    logic [D_WIDTH-1:0] old_s;
    logic [D_WIDTH-1:0] new_s;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = INIT;
            INIT: begin
                if (init_cnt_r == ADDR_LAST) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = INIT;
                end
            end
            RUN:     state_nxt_s = RUN;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Grants, RAM port drive and status; an asserted reset suppresses every RAM access
    always_comb begin
        upd_rdy_o     = 1'b0;
        rd_rdy_o      = 1'b0;
        ram_rd_en_o   = 1'b0;
        ram_rd_addr_o = {A_WIDTH{1'b0}};
        ram_wr_en_o   = 1'b0;
        ram_wr_addr_o = {A_WIDTH{1'b0}};
        ram_wr_data_o = {D_WIDTH{1'b0}};
        init_done_o   = (state_r == RUN);
        if (state_r == RUN && !rst_i) begin
            if (upd_val_i && rd_stb_i) begin
                rd_rdy_o  = ~rr_ptr_r;
                upd_rdy_o = rr_ptr_r;
            end else begin
                rd_rdy_o  = rd_stb_i;
                upd_rdy_o = upd_val_i;
            end
        end else begin
            rd_rdy_o  = 1'b0;
            upd_rdy_o = 1'b0;
        end
        if (rd_rdy_o) begin
            ram_rd_en_o   = 1'b1;
            ram_rd_addr_o = rd_flow_num_i;
        end else if (upd_rdy_o) begin
            ram_rd_en_o   = 1'b1;
            ram_rd_addr_o = upd_flow_i;
        end else begin
            ram_rd_en_o   = 1'b0;
            ram_rd_addr_o = {A_WIDTH{1'b0}};
        end
        if (rst_i) begin
            ram_wr_en_o = 1'b0;
        end else if (state_r == INIT) begin
            ram_wr_en_o   = 1'b1;
            ram_wr_addr_o = init_cnt_r;
            ram_wr_data_o = {D_WIDTH{1'b0}};
        end else if (s1_val_r && s1_upd_r) begin
            ram_wr_en_o   = 1'b1;
            ram_wr_addr_o = s1_flow_r;
            ram_wr_data_o = new_s;
        end else begin
            ram_wr_en_o = 1'b0;
        end
    end

    // Resolve stage: the previous write is still in flight in the RAM, so take it from F
    always_comb begin
        if (fwd_val_r && (fwd_flow_r == s1_flow_r)) begin
            old_s = fwd_data_r;
        end else begin
            old_s = ram_rd_data_i;
        end
        new_s = sat_add(old_s, s1_size_r);
    end

    // Pipeline, forward register, pointer and init counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_r      <= 1'b0;
            init_cnt_r    <= {A_WIDTH{1'b0}};
            s1_val_r      <= 1'b0;
            s1_upd_r      <= 1'b0;
            s1_flow_r     <= {A_WIDTH{1'b0}};
            s1_size_r     <= 16'd0;
            fwd_val_r     <= 1'b0;
            fwd_flow_r    <= {A_WIDTH{1'b0}};
            fwd_data_r    <= {D_WIDTH{1'b0}};
            rd_data_r     <= {D_WIDTH{1'b0}};
            rd_data_val_r <= 1'b0;
        end else begin
            if (rd_rdy_o && upd_val_i) begin
                rr_ptr_r <= 1'b1;
            end else if (upd_rdy_o && rd_stb_i) begin
                rr_ptr_r <= 1'b0;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
            if (state_r == INIT) begin
                init_cnt_r <= init_cnt_r + ADDR_ONE;
            end else begin
                init_cnt_r <= init_cnt_r;
            end
            s1_val_r  <= rd_rdy_o | upd_rdy_o;
            s1_upd_r  <= upd_rdy_o;
            s1_flow_r <= ram_rd_addr_o;
            s1_size_r <= upd_size_i;
            if (s1_val_r && s1_upd_r) begin
                fwd_val_r  <= 1'b1;
                fwd_flow_r <= s1_flow_r;
                fwd_data_r <= new_s;
            end else begin
                fwd_val_r  <= 1'b0;
            end
            if (s1_val_r && !s1_upd_r) begin
                rd_data_r     <= old_s;
                rd_data_val_r <= 1'b1;
            end else begin
                rd_data_val_r <= 1'b0;
            end
        end
    end

    assign rd_data_o     = rd_data_r;
    assign rd_data_val_o = rd_data_val_r;

endmodule

// File: tb/tb_flow_stat_arb.sv
// Testbench for flow_stat_arb: read-first RAM model, directed stimulus, and a
// queue-based scoreboard checked by an independent output monitor.
module tb_flow_stat_arb;

    localparam int AW = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          upd_val_i;
    logic [AW-1:0] upd_flow_i;
    logic [15:0]   upd_size_i;
    logic          upd_rdy_o;
    logic          rd_stb_i;
    logic [AW-1:0] rd_flow_num_i;
    logic          rd_rdy_o;
    logic [DW-1:0] rd_data_o;
    logic          rd_data_val_o;
    logic          init_done_o;
    logic          ram_rd_en_o;
    logic [AW-1:0] ram_rd_addr_o;
    logic [DW-1:0] ram_rd_data_i;
    logic          ram_wr_en_o;
    logic [AW-1:0] ram_wr_addr_o;
    logic [DW-1:0] ram_wr_data_o;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_wr[$];
    logic [DW-1:0] exp_rd[$];
    wr_t           mon_e;
    logic [DW-1:0] mon_d;
    logic [DW-1:0] mem [0:(1<<AW)-1];
    int            checks = 0;
    int            errors = 0;

    flow_stat_arb #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .upd_val_i     (upd_val_i),
        .upd_flow_i    (upd_flow_i),
        .upd_size_i    (upd_size_i),
        .upd_rdy_o     (upd_rdy_o),
        .rd_stb_i      (rd_stb_i),
        .rd_flow_num_i (rd_flow_num_i),
        .rd_rdy_o      (rd_rdy_o),
        .rd_data_o     (rd_data_o),
        .rd_data_val_o (rd_data_val_o),
        .init_done_o   (init_done_o),
        .ram_rd_en_o   (ram_rd_en_o),
        .ram_rd_addr_o (ram_rd_addr_o),
        .ram_rd_data_i (ram_rd_data_i),
        .ram_wr_en_o   (ram_wr_en_o),
        .ram_wr_addr_o (ram_wr_addr_o),
        .ram_wr_data_o (ram_wr_data_o)
    );

    always #5 clk = ~clk;

    // Simple dual-port RAM, read-first on collision; starts with junk so the clear matters
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hDEAD_0000 + i;
        ram_rd_data_i = 32'h0;
    end
    always @(posedge clk) begin
        if (ram_rd_en_o) ram_rd_data_i <= mem[ram_rd_addr_o];
        if (ram_wr_en_o) mem[ram_wr_addr_o] <= ram_wr_data_o;
    end

    // Monitor: pops the scoreboard whenever the DUT writes the RAM or returns read data
    always @(negedge clk) begin
        if (ram_wr_en_o) begin
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: got addr=%0d data=%h, required no write",
                         ram_wr_addr_o, ram_wr_data_o);
            end else begin
                mon_e = exp_wr.pop_front();
                if (ram_wr_addr_o !== mon_e.addr || ram_wr_data_o !== mon_e.data) begin
                    errors++;
                    $display("FAIL wr_data: got addr=%0d data=%h, required addr=%0d data=%h",
                             ram_wr_addr_o, ram_wr_data_o, mon_e.addr, mon_e.data);
                end
            end
        end
        if (rd_data_val_o) begin
            checks++;
            if (exp_rd.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: got data=%h, required no read data", rd_data_o);
            end else begin
                mon_d = exp_rd.pop_front();
                if (rd_data_o !== mon_d) begin
                    errors++;
                    $display("FAIL rd_data: got %h, required %h", rd_data_o, mon_d);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string name);
        chk(name, {59'd0, ram_rd_en_o, ram_wr_en_o, upd_rdy_o, rd_rdy_o, init_done_o}, 64'd0);
        chk({name, "_data"}, {ram_rd_addr_o, ram_wr_addr_o, ram_wr_data_o, rd_data_o,
                              rd_data_val_o}, 64'd0);
    endtask

    task automatic push_init();
        wr_t w;
        for (int i = 0; i < (1 << AW); i++) begin
            w.addr = i[AW-1:0];
            w.data = 32'h0;
            exp_wr.push_back(w);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer one update; on grant push the expected write (if any); returns 1 ns after the grant edge
    task automatic do_upd(input logic [AW-1:0] f, input logic [15:0] s,
                          input bit exp_en, input logic [DW-1:0] exp_val);
        bit  got;
        wr_t w;
        got        = 1'b0;
        upd_val_i  = 1'b1;
        upd_flow_i = f;
        upd_size_i = s;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (upd_rdy_o) begin
                got = 1'b1;
                break;
            end
        end
        chk("upd_granted", {63'd0, got}, 64'd1);
        if (got && exp_en) begin
            w.addr = f;
            w.data = exp_val;
            exp_wr.push_back(w);
        end
        @(posedge clk);
        #1;
        upd_val_i = 1'b0;
    endtask

    task automatic do_rd(input logic [AW-1:0] f, input logic [DW-1:0] exp_val, input bit timed);
        bit got;
        got           = 1'b0;
        rd_stb_i      = 1'b1;
        rd_flow_num_i = f;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rd_rdy_o) begin
                got = 1'b1;
                break;
            end
        end
        chk("rd_granted", {63'd0, got}, 64'd1);
        if (got) exp_rd.push_back(exp_val);
        @(posedge clk);
        #1;
        rd_stb_i = 1'b0;
        if (timed) begin
            @(negedge clk);
            chk("rd_lat_cycle1", {63'd0, rd_data_val_o}, 64'd0);
            @(negedge clk);
            chk("rd_lat_cycle2", {63'd0, rd_data_val_o}, 64'd1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_init();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (init_done_o) begin
                done = 1'b1;
                break;
            end
        end
        chk("init_done_timeout", {63'd0, done}, 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        wr_t w;
        rst_i         = 1'b1;
        upd_val_i     = 1'b0;
        upd_flow_i    = '0;
        upd_size_i    = 16'd0;
        rd_stb_i      = 1'b0;
        rd_flow_num_i = '0;

        // Init: 16 clearing writes in cycles 2..17, init_done from cycle 18
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset_vals");
        push_init();
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        for (int cyc = 1; cyc <= 18; cyc++) begin
            @(negedge clk);
            chk("init_wr_en", {63'd0, ram_wr_en_o}, {63'd0, (cyc >= 2 && cyc <= 17)});
            chk("init_done", {63'd0, init_done_o}, {63'd0, (cyc == 18)});
            chk("init_no_rdy", {62'd0, upd_rdy_o, rd_rdy_o}, 64'd0);
        end
        @(posedge clk);
        #1;

        // Back-to-back same flow, then an immediate read
        do_upd(4'd3, 16'd1, 1'b1, 32'd1);
        do_upd(4'd3, 16'd2, 1'b1, 32'd3);
        do_upd(4'd3, 16'd3, 1'b1, 32'd6);
        do_rd(4'd3, 32'd6, 1'b0);
        idle(3);

        // Contention on flow 5: R, U, R, U, R with reads 0, 10, 20
        exp_rd.push_back(32'd0);
        exp_rd.push_back(32'd10);
        exp_rd.push_back(32'd20);
        w.addr = 4'd5; w.data = 32'd10; exp_wr.push_back(w);
        w.addr = 4'd5; w.data = 32'd20; exp_wr.push_back(w);
        upd_val_i     = 1'b1;
        upd_flow_i    = 4'd5;
        upd_size_i    = 16'd10;
        rd_stb_i      = 1'b1;
        rd_flow_num_i = 4'd5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("cont_rd_gnt", {63'd0, rd_rdy_o}, {63'd0, (i % 2 == 0)});
            chk("cont_upd_gnt", {63'd0, upd_rdy_o}, {63'd0, (i % 2 == 1)});
            @(posedge clk);
        end
        #1;
        upd_val_i = 1'b0;
        rd_stb_i  = 1'b0;
        idle(3);

        // Saturation on flow 7, starting from a backdoor preload near the top
        mem[7] = 32'hFFFF_FF00;
        do_upd(4'd7, 16'h00F0, 1'b1, 32'hFFFF_FFF0);
        idle(2);
        do_upd(4'd7, 16'h0100, 1'b1, 32'hFFFF_FFFF);
        idle(2);
        do_rd(4'd7, 32'hFFFF_FFFF, 1'b0);
        do_upd(4'd7, 16'hFFFF, 1'b1, 32'hFFFF_FFFF);
        do_upd(4'd7, 16'h0001, 1'b1, 32'hFFFF_FFFF);
        do_rd(4'd7, 32'hFFFF_FFFF, 1'b0);
        idle(3);

        // Read on the cycle after an update of the same flow
        do_upd(4'd2, 16'd100, 1'b1, 32'd100);
        do_rd(4'd2, 32'd100, 1'b1);
        idle(3);

        // Reset while an update sits in S1: no write, reset values, INIT again
        do_upd(4'd9, 16'd50, 1'b0, 32'd0);
        rst_i = 1'b1;
        @(negedge clk);
        chk("rst_no_wr", {63'd0, ram_wr_en_o}, 64'd0);
        push_init();
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk_reset_vals("rst_mid_vals");
        wait_init();
        do_rd(4'd3, 32'd0, 1'b0);
        do_rd(4'd7, 32'd0, 1'b0);
        do_rd(4'd9, 32'd0, 1'b0);
        do_rd(4'd2, 32'd0, 1'b0);
        idle(5);

        chk("wr_queue_drained", exp_wr.size(), 64'd0);
        chk("rd_queue_drained", exp_rd.size(), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
